// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: FSM states and forwarding selects.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_REDIRECT   = 2'd3
  } hz_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// EX operand forwarding select for one source operand. The newer EX/MEM
// result takes priority over MEM/WB; writes to x0 are never forwarded.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic [REG_IDX_WIDTH-1:0] ex_rs_i,
  input  logic [REG_IDX_WIDTH-1:0] mem_rd_i,
  input  logic                     mem_reg_write_i,
  input  logic [REG_IDX_WIDTH-1:0] wb_rd_i,
  input  logic                     wb_reg_write_i,
  output logic [1:0]               fwd_o
);

  // Priority compare: EX/MEM first, then MEM/WB, else register file.
  always_comb begin
    fwd_o = FWD_RF;
    if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)) begin
      fwd_o = FWD_EXMEM;
    end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
      fwd_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core: stall/flush/freeze
// decisions, EX forwarding selects, saturating debug counters and a sticky
// data-memory wait timeout.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_IDX_WIDTH = 5,
  parameter int CNT_WIDTH     = 16,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_IDX_WIDTH-1:0] id_rs1,
  input  logic [REG_IDX_WIDTH-1:0] id_rs2,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [REG_IDX_WIDTH-1:0] ex_rs1,
  input  logic [REG_IDX_WIDTH-1:0] ex_rs2,
  input  logic [REG_IDX_WIDTH-1:0] ex_rd,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic                     ex_branch_taken,
  input  logic [REG_IDX_WIDTH-1:0] mem_rd,
  input  logic                     mem_reg_write,
  input  logic [REG_IDX_WIDTH-1:0] wb_rd,
  input  logic                     wb_reg_write,
  input  logic                     dmem_req,
  input  logic                     dmem_ready,
  output logic                     pc_write,
  output logic                     ifid_write,
  output logic                     ifid_flush,
  output logic                     idex_flush,
  output logic                     freeze,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b,
  output logic [1:0]               state,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     flush_cnt,
  output logic [CNT_WIDTH-1:0]     freeze_cnt,
  output logic                     mem_timeout
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);

  hz_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 mem_timeout_q;
  logic                 mem_wait, load_use, stall_ev, flush_ev, freeze_ev;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign mem_wait = dmem_req & ~dmem_ready;
  assign load_use = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Prioritised decision: memory wait, then redirect, then load-use, else run.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    freeze     = 1'b0;
    stall_ev   = 1'b0;
    flush_ev   = 1'b0;
    freeze_ev  = 1'b0;
    state_d    = ST_RUN;
    if (mem_wait) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      freeze_ev  = 1'b1;
      state_d    = ST_MEM_WAIT;
    end else if (ex_branch_taken) begin
      // The ID instruction is on the wrong path, so a pending load-use is moot.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_ev   = 1'b1;
      state_d    = ST_REDIRECT;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      stall_ev   = 1'b1;
      state_d    = ST_LOAD_STALL;
    end
  end

  // Wait timer counts consecutive wait cycles, saturating at the timeout.
  always_comb begin
    timer_d = '0;
    if (mem_wait) begin
      timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
    end
  end

  // State, counters, timer and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      freeze_cnt_q  <= '0;
      timer_q       <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (stall_ev)  stall_cnt_q  <= sat_inc(stall_cnt_q);
      if (flush_ev)  flush_cnt_q  <= sat_inc(flush_cnt_q);
      if (freeze_ev) freeze_cnt_q <= sat_inc(freeze_cnt_q);
      if (timer_d == TMR_MAX) mem_timeout_q <= 1'b1;
    end
  end

  forward_unit #(.REG_IDX_WIDTH(REG_IDX_WIDTH)) u_fwd_a (
    .ex_rs_i         (ex_rs1),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .fwd_o           (fwd_a)
  );

  forward_unit #(.REG_IDX_WIDTH(REG_IDX_WIDTH)) u_fwd_b (
    .ex_rs_i         (ex_rs2),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .fwd_o           (fwd_b)
  );

  assign state       = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign freeze_cnt  = freeze_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized bench for hazard_controller with a small
// behavioural reference model.
module tb_hazard_controller;

  localparam int RW   = 5;
  localparam int CW   = 3;
  localparam int MT   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read, ex_branch_taken;
  logic mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
  logic pc_write, ifid_write, ifid_flush, idex_flush, freeze, mem_timeout;
  logic [1:0] fwd_a, fwd_b, state;
  logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

  int compared = 0;
  int failed   = 0;

  // Reference model state
  int m_state, m_stall, m_flush, m_freeze, m_timer, m_timeout;

  hazard_controller #(.REG_IDX_WIDTH(RW), .CNT_WIDTH(CW), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .freeze_cnt(freeze_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Event classification straight from the decision rules.
  function automatic int m_event();   // 0 run, 1 load-use, 2 wait, 3 redirect
    bit lu;
    if (dmem_req && !dmem_ready) return 2;
    if (ex_branch_taken) return 3;
    lu = ex_mem_read && ex_reg_write && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    return lu ? 1 : 0;
  endfunction

  function automatic int m_fwd(input logic [RW-1:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2;  // EX/MEM
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 1;     // MEM/WB
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v + 1 > CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_stall = 0; m_flush = 0; m_freeze = 0; m_timer = 0; m_timeout = 0;
  endtask

  task automatic chk_regs(input string pfx);
    chk({pfx, ".state"},       32'(state),       32'(m_state));
    chk({pfx, ".stall_cnt"},   32'(stall_cnt),   32'(m_stall));
    chk({pfx, ".flush_cnt"},   32'(flush_cnt),   32'(m_flush));
    chk({pfx, ".freeze_cnt"},  32'(freeze_cnt),  32'(m_freeze));
    chk({pfx, ".mem_timeout"}, 32'(mem_timeout), 32'(m_timeout));
  endtask

  // One cycle: inputs are already applied (after a falling edge).
  task automatic step(input string pfx);
    int ev;
    #1;
    ev = m_event();
    chk({pfx, ".pc_write"},   32'(pc_write),   32'(ev == 0 || ev == 3));
    chk({pfx, ".ifid_write"}, 32'(ifid_write), 32'(ev == 0 || ev == 3));
    chk({pfx, ".ifid_flush"}, 32'(ifid_flush), 32'(ev == 3));
    chk({pfx, ".idex_flush"}, 32'(idex_flush), 32'(ev == 1 || ev == 3));
    chk({pfx, ".freeze"},     32'(freeze),     32'(ev == 2));
    chk({pfx, ".fwd_a"},      32'(fwd_a),      32'(m_fwd(ex_rs1)));
    chk({pfx, ".fwd_b"},      32'(fwd_b),      32'(m_fwd(ex_rs2)));
    @(posedge clk);
    m_state = ev;
    if (ev == 1) m_stall  = sat(m_stall);
    if (ev == 3) m_flush  = sat(m_flush);
    if (ev == 2) m_freeze = sat(m_freeze);
    m_timer = (ev == 2) ? ((m_timer < MT) ? m_timer + 1 : MT) : 0;
    if (m_timer == MT) m_timeout = 1;
    #1;
    chk_regs(pfx);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    ex_branch_taken = 0; mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic load_use_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #12;
    chk("reset", 32'({state, stall_cnt, flush_cnt, freeze_cnt, mem_timeout}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step("idle");

    // Load-use stall
    load_use_inputs();
    #1;
    chk("lu.pc_write", 32'(pc_write), 32'd0);
    chk("lu.idex_flush", 32'(idex_flush), 32'd1);
    step("lu");
    chk("lu.state", 32'(state), 32'd1);
    chk("lu.stall_cnt", 32'(stall_cnt), 32'd1);
    ex_rd = 0;
    #1;
    chk("lu_x0.pc_write", 32'(pc_write), 32'd1);
    step("lu_x0");

    // Branch beats load-use
    ex_rd = 5; ex_branch_taken = 1;
    #1;
    chk("br.ifid_flush", 32'(ifid_flush), 32'd1);
    chk("br.pc_write", 32'(pc_write), 32'd1);
    step("br");
    chk("br.flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br.stall_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait with a branch held in EX
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait.flush", 32'({ifid_flush, idex_flush, freeze}), 32'b001);
      step("wait");
    end
    chk("wait.freeze_cnt", 32'(freeze_cnt), 32'd3);
    chk("wait.timeout_pre", 32'(mem_timeout), 32'd0);
    dmem_ready = 1;
    #1;
    chk("wait.exit_flush", 32'(ifid_flush), 32'd1);
    step("wait_exit");
    idle_inputs();

    // Forwarding priority
    mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_reg_write = 1; wb_reg_write = 1;
    #1; chk("fwd.exmem", 32'(fwd_a), 32'd2);
    mem_reg_write = 0;
    #1; chk("fwd.memwb", 32'(fwd_a), 32'd1);
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0;
    #1; chk("fwd.rf", 32'(fwd_a), 32'd0);
    step("fwd");

    // Timeout: 6 wait cycles, flag from the 4th onward, sticky after ready
    idle_inputs();
    dmem_req = 1;
    for (int i = 1; i <= 6; i++) begin
      step("tmo");
      chk("tmo.flag", 32'(mem_timeout), 32'(i >= MT));
    end
    dmem_ready = 1;
    step("tmo_exit");
    chk("tmo.sticky", 32'(mem_timeout), 32'd1);

    // Counter saturation
    idle_inputs();
    load_use_inputs();
    for (int i = 0; i < 10; i++) step("sat");
    chk("sat.stall_cnt", 32'(stall_cnt), 32'd7);

    // Asynchronous reset in the middle of a wait
    idle_inputs();
    dmem_req = 1;
    step("arst_pre");
    step("arst_pre");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst.regs", 32'({state, stall_cnt, flush_cnt, freeze_cnt, mem_timeout}), 32'd0);
    chk("arst.freeze", 32'(freeze), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      id_rs1 = RW'($urandom_range(0, 3)); id_rs2 = RW'($urandom_range(0, 3));
      ex_rs1 = RW'($urandom_range(0, 3)); ex_rs2 = RW'($urandom_range(0, 3));
      ex_rd  = RW'($urandom_range(0, 3)); mem_rd = RW'($urandom_range(0, 3));
      wb_rd  = RW'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_reg_write = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
      dmem_req = ($urandom_range(0, 2) == 0); dmem_ready = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
